// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. An op is accepted on
//   START when not busy, then iterated one bit per cycle over XLEN cycles
//   (shift-add multiply, restoring divide on unsigned magnitudes). Divide by
//   zero and signed overflow bypass the iteration and finish immediately.
//
//   Ports:
//     CLK     rising-edge clock
//     RESET   asynchronous active-low reset
//     START   op request, sampled when BUSY=0 (IDLE or FIN)
//     KILL    synchronous abort, priority over START and iteration
//     SELECT  funct3 op code (MUL..REMU)
//     DATA1   rs1: multiplicand / dividend
//     DATA2   rs2: multiplier / divisor
//     BUSY    high while iterating
//     DONE    one-cycle pulse, RESULT valid
//     RESULT  registered result, held until the next op completes
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic            KILL,
   input  logic [2:0]      SELECT,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] hi, lo, opb;
   logic [2:0]      op;
   logic            neg_q, neg_r;

   // incoming op decode
   logic            accept;
   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div0, ovf, special;
   logic [XLEN-1:0] special_res;

   // iteration datapath
   logic [XLEN:0]     mul_sum, rem_sh;
   logic [XLEN-1:0]   rem_sub;
   logic              ge;
   logic [XLEN-1:0]   hi_it, lo_it;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, final_res;

   assign accept = START && !KILL && (state == IDLE || state == FIN);

   always_comb begin
      a_sgn = (SELECT == 3'b000) || (SELECT == 3'b001) || (SELECT == 3'b010) ||
              (SELECT == 3'b100) || (SELECT == 3'b110);
      b_sgn = (SELECT == 3'b000) || (SELECT == 3'b001) ||
              (SELECT == 3'b100) || (SELECT == 3'b110);
      a_neg = a_sgn && DATA1[XLEN-1];
      b_neg = b_sgn && DATA2[XLEN-1];
      a_mag = a_neg ? -DATA1 : DATA1;
      b_mag = b_neg ? -DATA2 : DATA2;
      div0  = SELECT[2] && (DATA2 == '0);
      ovf   = SELECT[2] && !SELECT[0] && (DATA2 == '1) &&
              (DATA1 == {1'b1, {(XLEN-1){1'b0}}});
      special     = div0 || ovf;
      special_res = '0;
      if (div0)
         special_res = SELECT[1] ? DATA1 : '1;
      else if (ovf)
         special_res = SELECT[1] ? '0 : DATA1;
   end

   // Both algorithms share hi/lo: multiply keeps {hi,lo} as the product
   // shifting right with the multiplier draining out of lo; divide keeps the
   // partial remainder in hi and shifts quotient bits into lo from the right.
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      rem_sh  = {hi, lo[XLEN-1]};
      ge      = rem_sh >= {1'b0, opb};
      // modulo-XLEN subtract is exact whenever ge holds, since the result < opb
      rem_sub = rem_sh[XLEN-1:0] - opb;
      if (op[2]) begin
         hi_it = ge ? rem_sub : rem_sh[XLEN-1:0];
         lo_it = {lo[XLEN-2:0], ge};
      end else begin
         hi_it = mul_sum[XLEN:1];
         lo_it = {mul_sum[0], lo[XLEN-1:1]};
      end
      prod   = {hi_it, lo_it};
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -lo_it : lo_it;
      rem_s  = neg_r ? -hi_it : hi_it;
      case (op)
         3'b000:                 final_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_res = quo_s;
         default:                final_res = rem_s;
      endcase
   end

   // state register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = special ? FIN : CALC;
         CALC: begin
            if (KILL)
               state_nx = IDLE;
            else if (count == '0)
               state_nx = FIN;
         end
         FIN: begin
            if (accept)
               state_nx = special ? FIN : CALC;
            else
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // outputs; KILL in FIN suppresses the pending DONE in the same cycle
   always_comb begin
      BUSY = (state == CALC);
      DONE = (state == FIN) && !KILL;
   end

   // datapath registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count  <= '0;
         hi     <= '0;
         lo     <= '0;
         opb    <= '0;
         op     <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         RESULT <= '0;
      end else if (accept) begin
         op    <= SELECT;
         hi    <= '0;
         lo    <= a_mag;
         opb   <= b_mag;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         count <= CW'(XLEN - 1);
         if (special)
            RESULT <= special_res;
      end else if (state == CALC && !KILL) begin
         hi    <= hi_it;
         lo    <= lo_it;
         count <= count - 1'b1;
         if (count == '0)
            RESULT <= final_res;
      end
   end

endmodule
